// File: rtl/hififo_wr_arbiter_if.sv
// Bundle of requester-side and TX-side signals of the write-request arbiter.
// The arbiter takes the slave view; whatever drives requests and wr_ready takes the master view.
interface hififo_wr_arbiter_if;
    logic [3:0]   enable;
    logic [3:0]   req_valid;
    logic [255:0] req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic         wr_valid;
    logic [63:0]  wr_data;
    logic         wr_last;
    logic [1:0]   wr_source;
    logic         wr_ready;
    logic         busy;
    logic         length_error;
    logic [15:0]  packet_count;

    modport master (
        output enable, req_valid, req_data, req_last, wr_ready,
        input  req_ready, wr_valid, wr_data, wr_last, wr_source,
               busy, length_error, packet_count
    );

    modport slave (
        input  enable, req_valid, req_data, req_last, wr_ready,
        output req_ready, wr_valid, wr_data, wr_last, wr_source,
               busy, length_error, packet_count
    );
endinterface

// File: rtl/hififo_wr_arbiter.sv
// Four-way round-robin packet arbiter feeding the PCIe TX write-request channel.
// A grant is held until the last beat of the packet; beats pass through combinationally.
module hififo_wr_arbiter #(
    parameter int MAX_BEATS = 16
) (
    input logic                clock,
    input logic                reset,
    hififo_wr_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [4:0] LAST_COUNT = 5'(MAX_BEATS - 1);

    state_t      state, state_next;
    logic [1:0]  grant, grant_next, last_served;
    logic [4:0]  beat_count;
    logic [15:0] packet_count;
    logic        length_error;
    logic [63:0] data_hold;
    logic [63:0] grant_data;
    logic [3:0]  candidates;
    logic        found;
    logic        xfer;
    logic        wr_valid;
    logic        wr_last;
    logic        busy;
    logic [3:0]  req_ready;

    assign candidates = bus.req_valid & bus.enable;
    assign grant_data = bus.req_data[{grant, 6'd0} +: 64];
    assign xfer       = wr_valid & bus.wr_ready;

    // Search starts just after the last-served requester and wraps back to it.
    // NOTE: every always_comb assigns defaults first so no latch can be inferred.
    always_comb begin
        grant_next = last_served;
        found      = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && candidates[last_served + 2'(i)]) begin
                grant_next = last_served + 2'(i);
                found      = 1'b1;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = GRANT;
            GRANT:   if (xfer && bus.req_last[grant]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
        busy      = 1'b0;
        req_ready = '0;
        if (state == GRANT) begin
            wr_valid         = bus.req_valid[grant];
            wr_last          = bus.req_last[grant];
            busy             = 1'b1;
            req_ready[grant] = bus.wr_ready;
        end
    end

    // NOTE: data_hold is reset too, so wr_data is never X before the first beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant        <= 2'd0;
            last_served  <= 2'd3;
            beat_count   <= 5'd0;
            packet_count <= 16'd0;
            length_error <= 1'b0;
            data_hold    <= 64'd0;
        end else begin
            if (state == IDLE && found) begin
                grant      <= grant_next;
                beat_count <= 5'd0;
            end
            if (wr_valid) data_hold <= grant_data;
            if (xfer) begin
                // Saturate so an oversized packet cannot wrap back into range.
                if (beat_count != 5'd31) beat_count <= beat_count + 5'd1;
                if (wr_last) begin
                    last_served  <= grant;
                    packet_count <= packet_count + 16'd1;
                end else if (beat_count == LAST_COUNT) begin
                    length_error <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_valid     = wr_valid;
    assign bus.wr_data      = wr_valid ? grant_data : data_hold;
    assign bus.wr_last      = wr_last;
    assign bus.wr_source    = grant;
    assign bus.req_ready    = req_ready;
    assign bus.busy         = busy;
    assign bus.length_error = length_error;
    assign bus.packet_count = packet_count;
endmodule
